cache_axi_bridge: RTL and testbench

- Downstream neighbour of the CPU-side SRAM interface; consumes its single-word inst-read and data-read/write requests.
- Converts each request into one AXI single-beat transaction on a shared master port.
- Arbitrates between instruction and data requests and returns a one-cycle valid pulse with read data.
- One transaction is outstanding at a time.

---
 rtl/cache_axi_bridge_pkg.sv | 16 +
 rtl/cache_axi_bridge_if.sv | 46 ++++
 rtl/cache_axi_bridge_axi_req_latch.sv | 29 ++
 rtl/cache_axi_bridge.sv | 130 +++++++++++++
 tb/tb_cache_axi_bridge.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/cache_axi_bridge_pkg.sv
// cache_axi_bridge_pkg: shared constants, FSM state encoding and request payload type for the cache-to-AXI bridge
package cache_axi_bridge_pkg;
    localparam logic       RST_ENABLE  = 1'b0;
    localparam logic [3:0] INST_ID_DEF = 4'd0;
    localparam logic [3:0] DATA_ID_DEF = 4'd1;
    localparam logic [3:0] AXI_LEN     = 4'd0;
    localparam logic [2:0] AXI_SIZE    = 3'b010;
    localparam logic [1:0] AXI_BURST   = 2'b01;
    typedef enum logic [2:0] {IDLE, I_AR, I_R, D_AR, D_R, D_WR, D_B} state_t;
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wd;
        logic [3:0]  wen;
        logic        wr;
    } data_req_t;
endpackage

// File: rtl/cache_axi_bridge_if.sv
// cache_axi_bridge_if: single-beat AXI master bus; master modport = bridge side, slave modport = memory side
interface cache_axi_bridge_if;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [3:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [3:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    modport master (
        output arid, araddr, arlen, arsize, arburst, arvalid, rready,
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        output wdata, wstrb, wlast, wvalid, bready,
        input  arready, rid, rdata, rresp, rlast, rvalid,
        input  awready, wready, bid, bresp, bvalid
    );
    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        input  wdata, wstrb, wlast, wvalid, bready,
        output arready, rid, rdata, rresp, rlast, rvalid,
        output awready, wready, bid, bresp, bvalid
    );
endinterface

// File: rtl/cache_axi_bridge_axi_req_latch.sv
// axi_req_latch: per-source pending flag and payload capture; ports clk, rst (async active-low), req, clr, din in; act, dout out
module axi_req_latch
    import cache_axi_bridge_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req,
    input  logic         clr,
    input  logic [W-1:0] din,
    output logic         act,
    output logic [W-1:0] dout
);
    logic         pend;
    logic [W-1:0] q;
    // act/dout expose a fresh request in the cycle it arrives so the FSM can start without waiting for the latch
    assign act  = pend | req;
    assign dout = pend ? q : din;
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ENABLE) begin
            pend <= 1'b0;
            q    <= '0;
        end else begin
            pend <= clr ? 1'b0 : (pend | req);
            if (req && !pend) q <= din;
        end
    end
endmodule

// File: rtl/cache_axi_bridge.sv
// cache_axi_bridge: turns single-word inst/data SRAM-style requests into single-beat AXI transactions, one at a time
// ports: clk, rst (async active-low); inst_addr/inst_ren in, inst_valid/inst_rd out;
//        data_addr/data_ren/data_wen/data_wd in, data_valid/data_rd out; ax = AXI master bus
module cache_axi_bridge
    import cache_axi_bridge_pkg::*;
#(
    parameter logic [3:0] INST_ID = INST_ID_DEF,
    parameter logic [3:0] DATA_ID = DATA_ID_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [31:0]         inst_addr,
    input  logic                inst_ren,
    output logic                inst_valid,
    output logic [31:0]         inst_rd,
    input  logic [31:0]         data_addr,
    input  logic                data_ren,
    input  logic [3:0]          data_wen,
    input  logic [31:0]         data_wd,
    output logic                data_valid,
    output logic [31:0]         data_rd,
    cache_axi_bridge_if.master  ax
);
    state_t      state;
    logic        i_act, d_act, i_clr, d_clr;
    logic [31:0] i_addr;
    data_req_t   d_in, d_pay;
    logic        unused;
    assign unused      = ^{ax.rresp, ax.bresp, ax.rid, ax.bid};
    assign ax.arlen    = AXI_LEN;
    assign ax.arsize   = AXI_SIZE;
    assign ax.arburst  = AXI_BURST;
    assign ax.awlen    = AXI_LEN;
    assign ax.awsize   = AXI_SIZE;
    assign ax.awburst  = AXI_BURST;
    assign ax.awid     = DATA_ID;
    assign ax.wlast    = 1'b1;
    // a read enable alongside nonzero byte enables makes the request a read
    assign d_in  = '{addr: data_addr, wd: data_wd, wen: data_wen, wr: (|data_wen) & ~data_ren};
    assign i_clr = state == I_R && ax.rvalid && ax.rlast;
    assign d_clr = (state == D_R && ax.rvalid && ax.rlast) || (state == D_B && ax.bvalid);
    axi_req_latch #(.W(32)) u_inst_latch (
        .clk(clk), .rst(rst), .req(inst_ren), .clr(i_clr), .din(inst_addr), .act(i_act), .dout(i_addr)
    );
    axi_req_latch #(.W($bits(data_req_t))) u_data_latch (
        .clk(clk), .rst(rst), .req(data_ren | (|data_wen)), .clr(d_clr), .din(d_in), .act(d_act), .dout(d_pay)
    );
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ENABLE) begin
            state      <= IDLE;
            ax.arid    <= '0;
            ax.araddr  <= '0;
            ax.arvalid <= 1'b0;
            ax.rready  <= 1'b0;
            ax.awaddr  <= '0;
            ax.awvalid <= 1'b0;
            ax.wdata   <= '0;
            ax.wstrb   <= '0;
            ax.wvalid  <= 1'b0;
            ax.bready  <= 1'b0;
            inst_valid <= 1'b0;
            inst_rd    <= '0;
            data_valid <= 1'b0;
            data_rd    <= '0;
        end else begin
            inst_valid <= 1'b0;
            data_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (d_act && d_pay.wr) begin
                        state      <= D_WR;
                        ax.awaddr  <= d_pay.addr;
                        ax.wdata   <= d_pay.wd;
                        ax.wstrb   <= d_pay.wen;
                        ax.awvalid <= 1'b1;
                        ax.wvalid  <= 1'b1;
                    end else if (d_act) begin
                        state      <= D_AR;
                        ax.araddr  <= d_pay.addr;
                        ax.arid    <= DATA_ID;
                        ax.arvalid <= 1'b1;
                    end else if (i_act) begin
                        state      <= I_AR;
                        ax.araddr  <= i_addr;
                        ax.arid    <= INST_ID;
                        ax.arvalid <= 1'b1;
                    end
                end
                I_AR, D_AR: begin
                    if (ax.arready) begin
                        ax.arvalid <= 1'b0;
                        ax.rready  <= 1'b1;
                        state      <= state == I_AR ? I_R : D_R;
                    end
                end
                I_R, D_R: begin
                    if (ax.rvalid && ax.rlast) begin
                        ax.rready <= 1'b0;
                        state     <= IDLE;
                        if (state == I_R) begin
                            inst_rd    <= ax.rdata;
                            inst_valid <= 1'b1;
                        end else begin
                            data_rd    <= ax.rdata;
                            data_valid <= 1'b1;
                        end
                    end
                end
                D_WR: begin
                    if (ax.awready) ax.awvalid <= 1'b0;
                    if (ax.wready) ax.wvalid <= 1'b0;
                    // each channel is done once its valid has dropped or is handshaking now
                    if ((!ax.awvalid || ax.awready) && (!ax.wvalid || ax.wready)) begin
                        ax.bready <= 1'b1;
                        state     <= D_B;
                    end
                end
                D_B: begin
                    if (ax.bvalid) begin
                        ax.bready  <= 1'b0;
                        data_rd    <= '0;
                        data_valid <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cache_axi_bridge.sv
// tb_cache_axi_bridge: scoreboard bench with a delay-configurable single-beat AXI slave
module tb_cache_axi_bridge;
    typedef struct { logic [31:0] addr; logic [3:0] id; } ar_t;
    typedef struct { logic [31:0] addr; logic [31:0] data; logic [3:0] strb; } aw_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] inst_addr, data_addr, data_wd, inst_rd, data_rd;
    logic        inst_ren, data_ren, inst_valid, data_valid;
    logic [3:0]  data_wen;
    cache_axi_bridge_if ax();

    cache_axi_bridge dut (
        .clk(clk), .rst(rst),
        .inst_addr(inst_addr), .inst_ren(inst_ren), .inst_valid(inst_valid), .inst_rd(inst_rd),
        .data_addr(data_addr), .data_ren(data_ren), .data_wen(data_wen), .data_wd(data_wd),
        .data_valid(data_valid), .data_rd(data_rd), .ax(ax)
    );

    ar_t         exp_ar[$];
    aw_t         exp_aw[$];
    logic [31:0] exp_inst[$];
    logic [31:0] exp_data[$];
    int n_chk = 0, n_fail = 0, n_ar = 0, n_aw = 0;
    int ar_delay = 0, r_delay = 0, aw_delay = 0, w_delay = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return a == 32'hBFC0_0000 ? 32'h3C1D_8000 : a ^ 32'hA5A5_5A5A;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_done(input int budget);
        int i = 0;
        while ((exp_ar.size() + exp_aw.size() + exp_inst.size() + exp_data.size()) != 0 && i < budget) begin
            @(negedge clk);
            i++;
        end
        check("drain", 64'(exp_ar.size() + exp_aw.size() + exp_inst.size() + exp_data.size()), 64'd0);
        repeat (3) @(negedge clk);
    endtask

    initial begin : slave
        int ar_cnt, r_cnt, aw_cnt, w_cnt;
        logic r_pend, aw_done, w_done;
        logic [31:0] r_addr;
        ar_t ar_s;
        forever begin
            @(negedge clk);
            if (!rst) begin
                {ax.arready, ax.rvalid, ax.rlast, ax.awready, ax.wready, ax.bvalid} = '0;
                ax.rdata = '0;
                ax.rid = '0;
                {ar_cnt, r_cnt, aw_cnt, w_cnt} = '0;
                {r_pend, aw_done, w_done} = '0;
                r_addr = '0;
            end else begin
                if (inst_valid) begin
                    if (exp_inst.size() == 0) check("inst_spurious", 64'(inst_valid), 64'd0);
                    else check("inst_rd", 64'(inst_rd), 64'(exp_inst.pop_front()));
                end
                if (data_valid) begin
                    if (exp_data.size() == 0) check("data_spurious", 64'(data_valid), 64'd0);
                    else check("data_rd", 64'(data_rd), 64'(exp_data.pop_front()));
                end
                if (ax.arready) begin
                    ax.arready = 1'b0;
                    r_pend = 1'b1;
                    r_cnt = r_delay;
                    ar_cnt = 0;
                    n_ar++;
                end else if (ax.arvalid) begin
                    if (ar_cnt >= ar_delay) begin
                        ax.arready = 1'b1;
                        r_addr = ax.araddr;
                        ax.rid = ax.arid;
                        if (exp_ar.size() == 0) check("ar_extra", 64'(ax.arvalid), 64'd0);
                        else begin
                            ar_s = exp_ar.pop_front();
                            check("ar_addr_id", 64'({ax.araddr, ax.arid}), 64'({ar_s.addr, ar_s.id}));
                        end
                    end else ar_cnt++;
                end
                if (ax.rvalid) begin
                    ax.rvalid = 1'b0;
                    ax.rlast = 1'b0;
                    r_pend = 1'b0;
                end else if (r_pend && ax.rready) begin
                    if (r_cnt == 0) begin
                        ax.rvalid = 1'b1;
                        ax.rlast = 1'b1;
                        ax.rdata = mem_rd(r_addr);
                    end else r_cnt--;
                end
                if (ax.awready) begin
                    ax.awready = 1'b0;
                    aw_done = 1'b1;
                end else if (ax.awvalid && !aw_done) begin
                    if (aw_cnt >= aw_delay) begin
                        ax.awready = 1'b1;
                        n_aw++;
                        if (exp_aw.size() == 0) check("aw_extra", 64'(ax.awvalid), 64'd0);
                        else check("aw_addr_id", 64'({ax.awaddr, ax.awid}), 64'({exp_aw[0].addr, 4'd1}));
                    end else aw_cnt++;
                end
                if (ax.wready) begin
                    ax.wready = 1'b0;
                    w_done = 1'b1;
                end else if (ax.wvalid && !w_done) begin
                    if (w_cnt >= w_delay) begin
                        ax.wready = 1'b1;
                        if (exp_aw.size() == 0) check("w_extra", 64'(ax.wvalid), 64'd0);
                        else check("w_data", 64'({ax.wdata, ax.wstrb, ax.wlast}), 64'({exp_aw[0].data, exp_aw[0].strb, 1'b1}));
                    end else w_cnt++;
                end
                if (ax.bvalid) begin
                    ax.bvalid = 1'b0;
                    {aw_done, w_done} = '0;
                    {aw_cnt, w_cnt} = '0;
                    if (exp_aw.size() > 0) void'(exp_aw.pop_front());
                end else if (aw_done && w_done && ax.bready) ax.bvalid = 1'b1;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int bad, early;
        {inst_ren, data_ren} = '0;
        data_wen = '0;
        inst_addr = '0;
        data_addr = '0;
        data_wd = '0;
        ax.rresp = '0;
        ax.bresp = '0;
        ax.bid = 4'd1;
        #3 rst = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_valids", 64'({ax.arvalid, ax.rready, ax.awvalid, ax.wvalid, ax.bready, inst_valid, data_valid}), 64'd0);
        check("rst_rdata", 64'({inst_rd, data_rd}), 64'd0);
        check("rst_addr", 64'({ax.araddr, ax.awaddr}), 64'd0);
        check("rst_wdata", 64'({ax.wdata, ax.wstrb}), 64'd0);
        check("axi_const", 64'({ax.arlen, ax.arsize, ax.arburst, ax.awlen, ax.awsize, ax.awburst, ax.wlast}),
              64'({4'd0, 3'b010, 2'b01, 4'd0, 3'b010, 2'b01, 1'b1}));
        rst = 1'b1;
        @(negedge clk);

        exp_ar.push_back('{32'hBFC0_0000, 4'd0});
        exp_inst.push_back(32'h3C1D_8000);
        inst_addr = 32'hBFC0_0000;
        inst_ren = 1'b1;
        @(negedge clk);
        inst_ren = 1'b0;
        check("t1_arvalid_c1", 64'({ax.arvalid, ax.araddr}), 64'({1'b1, 32'hBFC0_0000}));
        @(negedge clk);
        check("t1_ivalid_c2", 64'(inst_valid), 64'd0);
        @(negedge clk);
        check("t1_ivalid_c3", 64'(inst_valid), 64'd1);
        wait_done(40);

        exp_ar.push_back('{32'h8000_2000, 4'd1});
        exp_ar.push_back('{32'hBFC0_0040, 4'd0});
        exp_data.push_back(mem_rd(32'h8000_2000));
        exp_inst.push_back(mem_rd(32'hBFC0_0040));
        inst_addr = 32'hBFC0_0040;
        data_addr = 32'h8000_2000;
        inst_ren = 1'b1;
        data_ren = 1'b1;
        @(negedge clk);
        inst_ren = 1'b0;
        data_ren = 1'b0;
        wait_done(60);

        w_delay = 2;
        exp_aw.push_back('{32'h8000_1000, 32'hDEAD_BEEF, 4'b0011});
        exp_data.push_back(32'd0);
        data_addr = 32'h8000_1000;
        data_wd = 32'hDEAD_BEEF;
        data_wen = 4'b0011;
        @(negedge clk);
        data_wen = 4'b0000;
        check("wr_c1_aw_w", 64'({ax.awvalid, ax.wvalid}), 64'd3);
        @(negedge clk);
        check("wr_c2_aw_first", 64'({ax.awvalid, ax.wvalid}), 64'd1);
        check("wr_wstrb", 64'(ax.wstrb), 64'd3);
        wait_done(60);
        w_delay = 0;

        ar_delay = 5;
        r_delay = 4;
        exp_ar.push_back('{32'hBFC0_0100, 4'd0});
        exp_inst.push_back(mem_rd(32'hBFC0_0100));
        inst_addr = 32'hBFC0_0100;
        inst_ren = 1'b1;
        @(negedge clk);
        inst_ren = 1'b0;
        bad = 0;
        early = 0;
        for (int i = 1; i <= 11; i++) begin
            if (i <= 6 && (!ax.arvalid || ax.araddr != 32'hBFC0_0100)) bad++;
            if (inst_valid) early++;
            @(negedge clk);
        end
        check("bp_ar_stable", 64'(bad), 64'd0);
        check("bp_no_early", 64'(early), 64'd0);
        check("bp_ivalid_c12", 64'(inst_valid), 64'd1);
        wait_done(40);
        ar_delay = 0;
        r_delay = 0;

        exp_ar.push_back('{32'h8000_3000, 4'd1});
        exp_data.push_back(mem_rd(32'h8000_3000));
        data_addr = 32'h8000_3000;
        data_ren = 1'b1;
        repeat (3) @(negedge clk);
        data_ren = 1'b0;
        wait_done(40);

        r_delay = 10;
        exp_ar.push_back('{32'h8000_4000, 4'd1});
        data_addr = 32'h8000_4000;
        data_ren = 1'b1;
        @(negedge clk);
        data_ren = 1'b0;
        for (int i = 0; i < 20 && !ax.rready; i++) @(negedge clk);
        check("t6_in_read", 64'(ax.rready), 64'd1);
        rst = 1'b0;
        #1;
        check("t6_rst_valids", 64'({ax.arvalid, ax.rready, ax.awvalid, ax.wvalid, ax.bready, inst_valid, data_valid}), 64'd0);
        check("t6_rst_rdata", 64'({inst_rd, data_rd}), 64'd0);
        check("t6_rst_araddr", 64'(ax.araddr), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        r_delay = 0;
        @(negedge clk);
        exp_ar.push_back('{32'hBFC0_0200, 4'd0});
        exp_inst.push_back(mem_rd(32'hBFC0_0200));
        inst_addr = 32'hBFC0_0200;
        inst_ren = 1'b1;
        @(negedge clk);
        inst_ren = 1'b0;
        wait_done(40);

        check("ar_count", 64'(n_ar), 64'd7);
        check("aw_count", 64'(n_aw), 64'd1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
